cus19_dmem_arbiter: RTL and testbench
=====================================

# cus19_dmem_arbiter

Two-requester arbiter and sequencer in front of `cus19_data_memory`. It shares the single data-memory port between the CPU load/store unit and the cryptographic accelerator's data mover. It grants at most one access per cycle and routes the one-cycle-late read data back to the owning requester. The crypto port can lock the memory for multi-word bursts; a lock-length counter bounds how long the CPU can be starved.

## Interface
Parameters:
- Mem_Addr_Width, 11, data-memory address width
- Data_Width, 19, data word width
- Lock_Max, 8, maximum consecutive locked crypto grants while the CPU is waiting (must be ≥1)

Ports:
- clk_in  in  1  single clock; all state updates on rising edge
- rst_in  in  1  reset; synchronous, active-high
- cpu_req_in  in  1  CPU access request
- cpu_we_in  in  1  CPU write (1) / read (0)
- cpu_addr_in  in  Mem_Addr_Width  CPU address
- cpu_wdata_in  in  Data_Width  CPU write data
- cpu_gnt_out  out  1  CPU access accepted this cycle
- cpu_rvalid_out  out  1  CPU read data valid
- cpu_rdata_out  out  Data_Width  CPU read data
- cry_req_in, cry_we_in, cry_addr_in, cry_wdata_in  in  1/1/Mem_Addr_Width/Data_Width  crypto request fields; same meaning as the CPU fields
- cry_lock_in  in  1  crypto requests exclusive ownership
- cry_gnt_out, cry_rvalid_out, cry_rdata_out  out  1/1/Data_Width  crypto grant, read valid, read data
- mem_rd_out  out  1  to data memory `mem_rd_in`
- rd_addr_out  out  Mem_Addr_Width  to `rd_addr_in`
- mem_wr_out  out  1  to `mem_wr_in`
- wr_addr_out  out  Mem_Addr_Width  to `wr_addr_in`
- wr_data_out  out  Data_Width  to `wr_data_in`
- rd_data_in  in  Data_Width  from `rd_data_out`; registered, valid 1 cycle after `mem_rd`

## Operation
- Request/grant handshake:
  - A requester holds its req and fields stable until it sees its gnt.
  - gnt is combinational from req and state, and is asserted in the same cycle.
  - Grants are one-hot; at most one access per cycle.
- Command drive for the granted requester:
  - we=1: mem_wr_out=1, wr_addr_out=addr, wr_data_out=wdata.
  - we=0: mem_rd_out=1, rd_addr_out=addr.
  - Unused and idle memory outputs are driven to 0.
- Read return:
  - The owner tag and a pending flag are registered on a read grant.
  - The next cycle, the owner's rvalid=1 and rdata=rd_data_in. The other requester's rdata is 0.
  - Writes produce no rvalid.
- FSM states: ARB and LOCK.
- ARB:
  - Single requester: that requester is granted.
  - Both requesting: the requester not granted last wins (round-robin pointer `last_gnt`).
  - Crypto granted with cry_lock_in=1: go to LOCK, lock_cnt←1.
- LOCK:
  - Only crypto is granted; the CPU is held off.
  - Each crypto grant while cpu_req_in=1 increments lock_cnt. lock_cnt holds while the CPU is idle.
  - cry_lock_in=0 or cry_req_in=0 → return to ARB. The arbitration in that cycle follows ARB rules.
  - lock_cnt==Lock_Max and cpu_req_in=1: grant the CPU that cycle, lock_cnt←0, go to ARB with last_gnt=CPU.
- last_gnt updates on every grant.

## Timing
- Reset values:
  - All outputs 0.
  - State ARB, last_gnt=CRY (so the CPU wins the first tie).
  - lock_cnt=0, read pending cleared.
- Reset asserted mid-operation: the pending read return is discarded (no rvalid in the following cycle) and any lock is dropped.
- Latency:
  - Grant: 0 cycles.
  - Write commit: same edge as grant.
  - Read data: rvalid exactly 1 cycle after the read grant.
- Back-to-back: reads from alternating requesters return in grant order with no bubbles.
- Simultaneous lock request and CPU request in ARB: the round-robin decision comes first. A lock is taken only if crypto wins.
- Address and data pass straight through; no width conversion. Addresses outside the memory depth wrap modulo 2^Mem_Addr_Width.

## Structure
- Package `cus19_dmem_pkg`:
  - State enum {ARB, LOCK}.
  - Requester-id type {CPU=0, CRY=1}.
  - Lock counter width localparam, $clog2(Lock_Max+1).
- Sub-module `cus19_rr_arb2`: a 2-way round-robin pick from (req vector, last_gnt). It is combinational and reused by the top FSM.

## Test plan
- After reset, CPU write of 0x1A5A5 to address 3, then CPU read of address 3 → cpu_gnt_out=1 on the same cycle; cpu_rvalid_out=1 next cycle with cpu_rdata_out=0x1A5A5; crypto outputs stay 0.
- Both request reads every cycle (CPU addr 1, crypto addr 2) → grants alternate CPU, CRY, CPU…; each rvalid lands on the correct port one cycle later.
- Crypto locked burst of 4 writes while the CPU idles → 4 consecutive cry_gnt_out; the FSM returns to ARB when cry_lock_in drops.
- Crypto held locked with the CPU requesting continuously, Lock_Max=8 → 8 crypto grants, then 1 CPU grant, then crypto re-arbitrates.
- rst_in asserted in the cycle after a crypto read grant → no cry_rvalid_out; all outputs 0; the next tie goes to the CPU.

Source files
------------

// File: rtl/cus19_dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and
// the lock-counter width helper.
package cus19_dmem_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    CRY = 1'b1
  } req_id_t;

  localparam int LOCK_MAX_DEFAULT = 8;

  function automatic int lock_cnt_w(input int lock_max);
    return (lock_max < 1) ? 1 : $clog2(lock_max + 1);
  endfunction

  localparam int LOCK_CNT_W_DEFAULT = lock_cnt_w(LOCK_MAX_DEFAULT);

endpackage

// File: rtl/cus19_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not granted
// last wins; a single requester is always granted.
module cus19_rr_arb2
  import cus19_dmem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_gnt == CPU) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/cus19_dmem_arbiter.sv
// Shares the single data-memory port between the CPU and the crypto data
// mover, with a bounded crypto lock and one-cycle read-data return routing.
//
// state | meaning
// ARB   | round-robin between CPU and crypto
// LOCK  | crypto owns the memory; CPU admitted once lock_cnt reaches Lock_Max
module cus19_dmem_arbiter
  import cus19_dmem_pkg::*;
#(
  parameter int Mem_Addr_Width = 11,
  parameter int Data_Width     = 19,
  parameter int Lock_Max       = LOCK_MAX_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cpu_req_in,
  input  logic                      cpu_we_in,
  input  logic [Mem_Addr_Width-1:0] cpu_addr_in,
  input  logic [Data_Width-1:0]     cpu_wdata_in,
  output logic                      cpu_gnt_out,
  output logic                      cpu_rvalid_out,
  output logic [Data_Width-1:0]     cpu_rdata_out,
  input  logic                      cry_req_in,
  input  logic                      cry_we_in,
  input  logic [Mem_Addr_Width-1:0] cry_addr_in,
  input  logic [Data_Width-1:0]     cry_wdata_in,
  input  logic                      cry_lock_in,
  output logic                      cry_gnt_out,
  output logic                      cry_rvalid_out,
  output logic [Data_Width-1:0]     cry_rdata_out,
  output logic                      mem_rd_out,
  output logic [Mem_Addr_Width-1:0] rd_addr_out,
  output logic                      mem_wr_out,
  output logic [Mem_Addr_Width-1:0] wr_addr_out,
  output logic [Data_Width-1:0]     wr_data_out,
  input  logic [Data_Width-1:0]     rd_data_in
);

  localparam int CntW = lock_cnt_w(Lock_Max);
  localparam logic [CntW-1:0] CntMax = CntW'(Lock_Max);

  state_t                  state_q, state_d;
  req_id_t                 last_q, last_d;
  req_id_t                 owner_q, owner_d;
  logic                    pend_q, pend_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [1:0]              rr_gnt;
  logic [1:0]              gnt;
  logic                    any_gnt;
  logic                    we_sel;
  logic [Mem_Addr_Width-1:0] addr_sel;
  logic [Data_Width-1:0]   wdata_sel;

  cus19_rr_arb2 u_rr (
    .req      ({cry_req_in, cpu_req_in}),
    .last_gnt (last_q),
    .gnt      (rr_gnt)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ARB;
      last_q  <= CRY;
      owner_q <= CPU;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt     = 2'b00;
    unique case (state_q)
      ARB: begin
        gnt = rr_gnt;
        if (rr_gnt[CRY] && cry_lock_in) begin
          state_d = LOCK;
          cnt_d   = CntW'(1);
        end
      end
      LOCK: begin
        if (cpu_req_in && (cnt_q == CntMax)) begin
          gnt     = 2'b01;
          state_d = ARB;
          cnt_d   = '0;
        end else if (!cry_lock_in || !cry_req_in) begin
          // Releasing the lock still arbitrates normally this cycle.
          gnt     = rr_gnt;
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          gnt = 2'b10;
          if (cpu_req_in) cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
    if (rst_in) gnt = 2'b00;
    if (gnt[CPU])      last_d = CPU;
    else if (gnt[CRY]) last_d = CRY;
  end

  assign any_gnt   = |gnt;
  assign we_sel    = gnt[CRY] ? cry_we_in    : cpu_we_in;
  assign addr_sel  = gnt[CRY] ? cry_addr_in  : cpu_addr_in;
  assign wdata_sel = gnt[CRY] ? cry_wdata_in : cpu_wdata_in;

  assign pend_d  = any_gnt & ~we_sel;
  assign owner_d = gnt[CRY] ? CRY : CPU;

  assign cpu_gnt_out = gnt[CPU];
  assign cry_gnt_out = gnt[CRY];

  assign mem_wr_out  = any_gnt & we_sel;
  assign mem_rd_out  = any_gnt & ~we_sel;
  assign wr_addr_out = mem_wr_out ? addr_sel  : '0;
  assign wr_data_out = mem_wr_out ? wdata_sel : '0;
  assign rd_addr_out = mem_rd_out ? addr_sel  : '0;

  // A read in flight when reset arrives is dropped immediately.
  assign cpu_rvalid_out = pend_q & (owner_q == CPU) & ~rst_in;
  assign cry_rvalid_out = pend_q & (owner_q == CRY) & ~rst_in;
  assign cpu_rdata_out  = cpu_rvalid_out ? rd_data_in : '0;
  assign cry_rdata_out  = cry_rvalid_out ? rd_data_in : '0;

endmodule

// File: tb/tb_cus19_dmem_arbiter.sv
// Directed bench for cus19_dmem_arbiter with a registered-read memory model
// behind the arbiter's memory port.
module tb_cus19_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 19;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          cpu_req_in, cpu_we_in;
  logic [AW-1:0] cpu_addr_in;
  logic [DW-1:0] cpu_wdata_in;
  logic          cpu_gnt_out, cpu_rvalid_out;
  logic [DW-1:0] cpu_rdata_out;
  logic          cry_req_in, cry_we_in, cry_lock_in;
  logic [AW-1:0] cry_addr_in;
  logic [DW-1:0] cry_wdata_in;
  logic          cry_gnt_out, cry_rvalid_out;
  logic [DW-1:0] cry_rdata_out;
  logic          mem_rd_out, mem_wr_out;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic [DW-1:0] wr_data_out;
  logic [DW-1:0] rd_data_in;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  cus19_dmem_arbiter #(.Mem_Addr_Width(AW), .Data_Width(DW), .Lock_Max(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cpu_req_in    (cpu_req_in),
    .cpu_we_in     (cpu_we_in),
    .cpu_addr_in   (cpu_addr_in),
    .cpu_wdata_in  (cpu_wdata_in),
    .cpu_gnt_out   (cpu_gnt_out),
    .cpu_rvalid_out(cpu_rvalid_out),
    .cpu_rdata_out (cpu_rdata_out),
    .cry_req_in    (cry_req_in),
    .cry_we_in     (cry_we_in),
    .cry_addr_in   (cry_addr_in),
    .cry_wdata_in  (cry_wdata_in),
    .cry_lock_in   (cry_lock_in),
    .cry_gnt_out   (cry_gnt_out),
    .cry_rvalid_out(cry_rvalid_out),
    .cry_rdata_out (cry_rdata_out),
    .mem_rd_out    (mem_rd_out),
    .rd_addr_out   (rd_addr_out),
    .mem_wr_out    (mem_wr_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .rd_data_in    (rd_data_in)
  );

  always @(posedge clk_in) begin
    if (mem_wr_out) mem[wr_addr_out] <= wr_data_out;
    if (mem_rd_out) rd_data_in <= mem[rd_addr_out];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_all();
    cpu_req_in = 0; cpu_we_in = 0; cpu_addr_in = '0; cpu_wdata_in = '0;
    cry_req_in = 0; cry_we_in = 0; cry_addr_in = '0; cry_wdata_in = '0;
    cry_lock_in = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cpu_gnt"}, 32'(cpu_gnt_out), 0);
    check({tag, "_cry_gnt"}, 32'(cry_gnt_out), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd_out), 0);
    check({tag, "_mem_wr"}, 32'(mem_wr_out), 0);
    check({tag, "_cpu_rv"}, 32'(cpu_rvalid_out), 0);
    check({tag, "_cry_rv"}, 32'(cry_rvalid_out), 0);
    check({tag, "_cry_rd"}, 32'(cry_rdata_out), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[1] = 19'h00111;
    mem[2] = 19'h00222;
    rd_data_in = '0;
    idle_all();
    rst_in = 1;
    cycle();

    // Reset gates grants even with requests present.
    cpu_req_in = 1; cry_req_in = 1;
    #1;
    check_quiet("rst");
    cycle();
    idle_all();
    rst_in = 0;
    cycle();

    // CPU write then read back of address 3.
    cpu_req_in = 1; cpu_we_in = 1; cpu_addr_in = 11'd3; cpu_wdata_in = 19'h1A5A5;
    #1;
    check("wr_cpu_gnt", 32'(cpu_gnt_out), 1);
    check("wr_cry_gnt", 32'(cry_gnt_out), 0);
    check("wr_mem_wr", 32'(mem_wr_out), 1);
    check("wr_mem_rd", 32'(mem_rd_out), 0);
    check("wr_addr", 32'(wr_addr_out), 3);
    check("wr_data", 32'(wr_data_out), 32'h1A5A5);
    cycle();
    check("wr_no_rvalid", 32'(cpu_rvalid_out), 0);
    cpu_we_in = 0;
    #1;
    check("rd_cpu_gnt", 32'(cpu_gnt_out), 1);
    check("rd_mem_rd", 32'(mem_rd_out), 1);
    check("rd_addr", 32'(rd_addr_out), 3);
    check("rd_wr_addr_idle", 32'(wr_addr_out), 0);
    cycle();
    idle_all();
    check("rd_cpu_rvalid", 32'(cpu_rvalid_out), 1);
    check("rd_cpu_rdata", 32'(cpu_rdata_out), 32'h1A5A5);
    check("rd_cry_rvalid", 32'(cry_rvalid_out), 0);
    check("rd_cry_rdata", 32'(cry_rdata_out), 0);
    cycle();

    // Both read every cycle; last grant was CPU so crypto goes first.
    cpu_req_in = 1; cpu_addr_in = 11'd1;
    cry_req_in = 1; cry_addr_in = 11'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt%0d_cry_gnt", i), 32'(cry_gnt_out), (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_cpu_gnt", i), 32'(cpu_gnt_out), (i % 2 == 0) ? 0 : 1);
      check($sformatf("alt%0d_rd_addr", i), 32'(rd_addr_out), (i % 2 == 0) ? 2 : 1);
      cycle();
      check($sformatf("alt%0d_cry_rv", i), 32'(cry_rvalid_out), (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_cpu_rv", i), 32'(cpu_rvalid_out), (i % 2 == 0) ? 0 : 1);
      check($sformatf("alt%0d_data", i),
            32'((i % 2 == 0) ? cry_rdata_out : cpu_rdata_out),
            (i % 2 == 0) ? 32'h222 : 32'h111);
    end
    idle_all();
    cycle();

    // Locked crypto write burst with the CPU idle.
    cry_req_in = 1; cry_lock_in = 1; cry_we_in = 1;
    for (int i = 0; i < 4; i++) begin
      cry_addr_in  = AW'(10 + i);
      cry_wdata_in = DW'(32'h30000 + i);
      #1;
      check($sformatf("burst%0d_gnt", i), 32'(cry_gnt_out), 1);
      check($sformatf("burst%0d_wr", i), 32'(mem_wr_out), 1);
      check($sformatf("burst%0d_addr", i), 32'(wr_addr_out), 10 + i);
      cycle();
    end
    idle_all();
    cycle();
    cry_req_in = 1; cry_addr_in = 11'd12;
    #1;
    check("post_burst_cry_gnt", 32'(cry_gnt_out), 1);
    cycle();
    idle_all();
    check("post_burst_rv", 32'(cry_rvalid_out), 1);
    check("post_burst_data", 32'(cry_rdata_out), 32'h30002);
    cycle();

    // Starvation bound: crypto locks alone, CPU joins, CPU admitted after 8 grants.
    cry_req_in = 1; cry_lock_in = 1; cry_addr_in = 11'd2;
    cpu_addr_in = 11'd1;
    for (int i = 0; i < 10; i++) begin
      cpu_req_in = (i != 0);
      #1;
      check($sformatf("lock%0d_cpu_gnt", i), 32'(cpu_gnt_out), (i == 8) ? 1 : 0);
      check($sformatf("lock%0d_cry_gnt", i), 32'(cry_gnt_out), (i == 8) ? 0 : 1);
      cycle();
      if (i == 8) begin
        check("lock_cpu_rv", 32'(cpu_rvalid_out), 1);
        check("lock_cpu_data", 32'(cpu_rdata_out), 32'h111);
      end
    end

    // Reset in the cycle after a crypto read grant.
    cpu_req_in = 0;
    #1;
    check("pre_rst_cry_gnt", 32'(cry_gnt_out), 1);
    cycle();
    rst_in = 1; cpu_req_in = 1; cry_req_in = 0;
    #1;
    check_quiet("midrst");
    cycle();
    rst_in = 0;
    cry_req_in = 1; cry_lock_in = 1;
    #1;
    check("after_rst_cpu_gnt", 32'(cpu_gnt_out), 1);
    check("after_rst_cry_gnt", 32'(cry_gnt_out), 0);
    check("after_rst_cry_rv", 32'(cry_rvalid_out), 0);
    cycle();
    idle_all();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
